// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the bypassed, scoreboarded register file.
package regfile_sb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on load return.
// Stall is combinational from the current read indices and the issuing destination.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_run,
  input  logic [NREAD*ADDR_W-1:0] i_rd_addr,
  input  logic                    i_wb_en,
  input  logic [ADDR_W-1:0]       i_wb_addr,
  input  logic                    i_iss_en,
  input  logic [ADDR_W-1:0]       i_iss_dst,
  output logic                    o_stall,
  output logic [2**ADDR_W-1:0]    o_pending
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_next;
  logic              w_set;
  logic              w_clr;
  logic              w_stall;
  logic [ADDR_W-1:0] w_ra;

  assign w_set = i_run && i_iss_en && (i_iss_dst != ADDR_W'(ZERO_REG));
  assign w_clr = i_run && i_wb_en;

  // Set is applied after clear so a fresh load to the same entry stays outstanding.
  always_comb begin
    w_next = r_pending;
    if (w_clr) w_next[i_wb_addr] = 1'b0;
    if (w_set) w_next[i_iss_dst] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= w_next;
  end

  always_comb begin
    w_stall = 1'b0;
    w_ra    = '0;
    if (i_run) begin
      for (int k = 0; k < NREAD; k++) begin
        w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];
        if (r_pending[w_ra] && !((BYPASS != 0) && i_wb_en && (i_wb_addr == w_ra)))
          w_stall = 1'b1;
      end
      if (i_iss_en && r_pending[i_iss_dst]) w_stall = 1'b1;
    end
  end

  assign o_stall   = w_stall;
  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// Two-write-port register file with zero-latency reads, write bypass, load scoreboard and a
// post-reset clear sweep; ready rises 2**ADDR_W cycles after reset release.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic                    o_ready,
  input  logic [NREAD*ADDR_W-1:0] i_rd_addr,
  output logic [NREAD*DATA_W-1:0] o_rd_data,
  input  logic                    i_wa_en,
  input  logic [ADDR_W-1:0]       i_wa_addr,
  input  logic [DATA_W-1:0]       i_wa_data,
  input  logic                    i_wb_en,
  input  logic [ADDR_W-1:0]       i_wb_addr,
  input  logic [DATA_W-1:0]       i_wb_data,
  input  logic                    i_iss_en,
  input  logic [ADDR_W-1:0]       i_iss_dst,
  output logic                    o_stall,
  output logic [2**ADDR_W-1:0]    o_pending
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_e         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic                    w_run;
  logic [NREAD*DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0]       w_ra;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it. Port B is written last so it wins a collision.
  always_ff @(posedge i_clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (i_wa_en && (i_wa_addr != ADDR_W'(ZERO_REG))) r_mem[i_wa_addr] <= i_wa_data;
      if (i_wb_en && (i_wb_addr != ADDR_W'(ZERO_REG))) r_mem[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_ra      = '0;
    for (int k = 0; k < NREAD; k++) begin
      w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];
      if (!w_run || (w_ra == ADDR_W'(ZERO_REG)))
        w_rd_data[k*DATA_W +: DATA_W] = '0;
      else if ((BYPASS != 0) && i_wb_en && (i_wb_addr == w_ra))
        w_rd_data[k*DATA_W +: DATA_W] = i_wb_data;
      else if ((BYPASS != 0) && i_wa_en && (i_wa_addr == w_ra))
        w_rd_data[k*DATA_W +: DATA_W] = i_wa_data;
      else
        w_rd_data[k*DATA_W +: DATA_W] = r_mem[w_ra];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .BYPASS (BYPASS)
  ) u_sb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_run     (w_run),
    .i_rd_addr (i_rd_addr),
    .i_wb_en   (i_wb_en),
    .i_wb_addr (i_wb_addr),
    .i_iss_en  (i_iss_en),
    .i_iss_dst (i_iss_dst),
    .o_stall   (o_stall),
    .o_pending (o_pending)
  );

  assign o_ready   = r_ready;
  assign o_rd_data = w_rd_data;

endmodule
